// File: rtl/hazard_fwd_scoreboard_pkg.sv
// Shared widths, forward-select encodings and the per-stage slot layout
// for the ID-stage hazard/forwarding scoreboard.
package hazard_fwd_scoreboard_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CNT_WIDTH      = 32;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int NUM_SLOTS = 3;  // index 0 = EX, 1 = MEM, 2 = WB

  typedef struct packed {
    logic                      vld;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      wen;
    logic                      is_load;
  } slot_t;

  // Youngest producer wins: EX beats MEM beats WB.
  function automatic logic [1:0] fwd_pick(input logic [NUM_SLOTS-1:0] hit);
    if (hit[0])      return FWD_EX;
    else if (hit[1]) return FWD_MEM;
    else if (hit[2]) return FWD_WB;
    else             return FWD_REG;
  endfunction
endpackage

// File: rtl/hazard_fwd_scoreboard_if.sv
// ID-stage decode inputs and forward/stall controls between ID and the scoreboard.
interface hazard_fwd_scoreboard_if
  import hazard_fwd_scoreboard_pkg::*;
#(
  parameter int RAW = REG_ADDR_WIDTH,
  parameter int CW  = CNT_WIDTH
) ();
  logic           id_valid;
  logic [RAW-1:0] id_rs1;
  logic [RAW-1:0] id_rs2;
  logic           id_rs1_used;
  logic           id_rs2_used;
  logic [RAW-1:0] id_rd;
  logic           id_rd_wen;
  logic           id_is_load;
  logic           flush;
  logic           mem_stall;
  logic [1:0]     fwd1_sel;
  logic [1:0]     fwd2_sel;
  logic           stall_id;
  logic           bubble_ex;
  logic [CW-1:0]  load_use_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_wen, id_is_load, flush, mem_stall,
    input  fwd1_sel, fwd2_sel, stall_id, bubble_ex, load_use_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_wen, id_is_load, flush, mem_stall,
    output fwd1_sel, fwd2_sel, stall_id, bubble_ex, load_use_cnt
  );
endinterface

// File: rtl/hazard_fwd_scoreboard_stage_hit_cmp.sv
// Compares one downstream stage slot against one ID source operand.
module stage_hit_cmp
  import hazard_fwd_scoreboard_pkg::*;
(
  input  slot_t                     slot,
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic                      rs_used,
  output logic                      hit
);
  // x0 is hardwired zero, so a write to it never produces a forward.
  assign hit = slot.vld & slot.wen & (slot.rd != '0) & (slot.rd == rs) & rs_used;
endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// Tracks in-flight writes in EX/MEM/WB and drives operand forward selects
// plus load-use stall/bubble control to the ID operand mux.
module hazard_fwd_scoreboard
  import hazard_fwd_scoreboard_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  hazard_fwd_scoreboard_if.slave   bus
);
  slot_t                ex_q, mem_q, wb_q;
  slot_t                slots [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit1, hit2;
  logic                 load_use;
  logic [CNT_WIDTH-1:0] cnt_q;

  always_comb begin
    slots[0] = ex_q;
    slots[1] = mem_q;
    slots[2] = wb_q;
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    stage_hit_cmp u_rs1 (
      .slot    (slots[s]),
      .rs      (bus.id_rs1),
      .rs_used (bus.id_rs1_used),
      .hit     (hit1[s])
    );
    stage_hit_cmp u_rs2 (
      .slot    (slots[s]),
      .rs      (bus.id_rs2),
      .rs_used (bus.id_rs2_used),
      .hit     (hit2[s])
    );
  end

  assign load_use     = bus.id_valid & (hit1[0] | hit2[0]) & ex_q.is_load;
  assign bus.fwd1_sel = fwd_pick(hit1);
  assign bus.fwd2_sel = fwd_pick(hit2);
  assign bus.stall_id = load_use | bus.mem_stall;
  // A frozen pipe cannot take a bubble; flush must be held until the freeze lifts.
  assign bus.bubble_ex    = (load_use | bus.flush) & ~bus.mem_stall;
  assign bus.load_use_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.mem_stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bus.bubble_ex) ex_q <= '0;
      else ex_q <= '{vld: bus.id_valid, rd: bus.id_rd, wen: bus.id_rd_wen,
                     is_load: bus.id_is_load};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (load_use & ~bus.mem_stall & ~bus.flush & ~(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Directed bench for hazard_fwd_scoreboard: forwarding priority, load-use,
// mem_stall freeze, flush interaction and asynchronous reset.
module tb_hazard_fwd_scoreboard;
  import hazard_fwd_scoreboard_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  hazard_fwd_scoreboard_if bus ();

  hazard_fwd_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wen, input logic ld);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs1_used = u1;
    bus.id_rs2      = rs2;
    bus.id_rs2_used = u2;
    bus.id_rd       = rd;
    bus.id_rd_wen   = wen;
    bus.id_is_load  = ld;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] f1, input logic [1:0] f2,
                         input logic st, input logic bb, input logic [31:0] cnt);
    chk({tag, ".fwd1"},   32'(bus.fwd1_sel),  32'(f1));
    chk({tag, ".fwd2"},   32'(bus.fwd2_sel),  32'(f2));
    chk({tag, ".stall"},  32'(bus.stall_id),  32'(st));
    chk({tag, ".bubble"}, 32'(bus.bubble_ex), 32'(bb));
    chk({tag, ".cnt"},    bus.load_use_cnt,   cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_stall = 1'b0;
    set_id(1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 1);
    chk_out("reset", FWD_REG, FWD_REG, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // A: ADD x5,x1,x2
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    chk_out("A", FWD_REG, FWD_REG, 0, 0, 0);
    tick();
    // B: ADD x6,x5,x1 -> x5 in EX
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    chk_out("B_ex", FWD_EX, FWD_REG, 0, 0, 0);
    tick();
    // C: reads x5 (now MEM), writes nothing
    set_id(1, 5'd5, 1, 5'd3, 1, 5'd0, 0, 0);
    chk_out("C_mem", FWD_MEM, FWD_REG, 0, 0, 0);
    tick();
    // D: reads x5 (now WB), writes x7
    set_id(1, 5'd5, 1, 5'd3, 1, 5'd7, 1, 0);
    chk_out("D_wb", FWD_WB, FWD_REG, 0, 0, 0);
    tick();
    // E: writes x7 again, reads x6 (in WB)
    set_id(1, 5'd4, 1, 5'd6, 1, 5'd7, 1, 0);
    chk_out("E_wb2", FWD_REG, FWD_WB, 0, 0, 0);
    tick();
    // F: x7 in EX and MEM -> EX wins; rs1=x0 never forwards; writes x0
    set_id(1, 5'd0, 1, 5'd7, 1, 5'd0, 1, 0);
    chk_out("F_prio", FWD_REG, FWD_EX, 0, 0, 0);
    tick();
    // G: EX holds x0 write, x7 in MEM (E) and WB (D) -> MEM
    set_id(1, 5'd0, 1, 5'd7, 1, 5'd0, 1, 0);
    chk_out("G_x0", FWD_REG, FWD_MEM, 0, 0, 0);
    tick();
    // H: LD x9
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd9, 1, 1);
    chk_out("H_ld", FWD_REG, FWD_REG, 0, 0, 0);
    tick();
    // I: ADD x10,x9,x9 -> load-use
    set_id(1, 5'd9, 1, 5'd9, 1, 5'd10, 1, 0);
    chk_out("I_lu", FWD_EX, FWD_EX, 1, 1, 0);
    tick();
    chk_out("I_after", FWD_MEM, FWD_MEM, 0, 0, 1);

    // Freeze with the load in MEM
    bus.mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("frz%0d", i), FWD_MEM, FWD_MEM, 1, 0, 1);
      tick();
    end
    bus.mem_stall = 1'b0;
    #1;
    chk_out("unfrz", FWD_MEM, FWD_MEM, 0, 0, 1);
    tick();

    // J: LD x11, reads x10 (I in EX)
    set_id(1, 5'd10, 1, 5'd0, 0, 5'd11, 1, 1);
    chk_out("J", FWD_EX, FWD_REG, 0, 0, 1);
    tick();
    // K: reads x11 with flush in the same cycle; rs2 unused
    bus.flush = 1'b1;
    set_id(1, 5'd11, 1, 5'd11, 0, 5'd12, 1, 0);
    chk_out("K_flush", FWD_EX, FWD_REG, 1, 1, 1);
    tick();
    bus.flush = 1'b0;
    #1;
    chk_out("K_after", FWD_MEM, FWD_REG, 0, 0, 1);
    tick();
    // K is now in EX writing x12
    set_id(1, 5'd12, 1, 5'd11, 1, 5'd0, 0, 0);
    chk_out("L", FWD_EX, FWD_WB, 0, 0, 1);

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", FWD_REG, FWD_REG, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_out("rst_post", FWD_REG, FWD_REG, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
